// File: rtl/armleocpu_regfile_frontend_pkg.sv
// Shared defaults for the register-file front end and its storage lanes.
package armleocpu_regfile_frontend_pkg;

  localparam int unsigned ELEMENTS_W_DEF = 5;
  localparam int unsigned WIDTH_DEF      = 32;

endpackage

// File: rtl/armleocpu_regfile_one_lane.sv
// One register-file lane: single synchronous read port, single write port.
// Storage carries no reset; the front end zero-fills it after reset.
module armleocpu_regfile_one_lane
  import armleocpu_regfile_frontend_pkg::*;
#(
  parameter int unsigned ELEMENTS_W = ELEMENTS_W_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic [ELEMENTS_W-1:0] i_readaddress,
  input  logic                  i_read,
  output logic [WIDTH-1:0]      o_readdata,
  input  logic [ELEMENTS_W-1:0] i_writeaddress,
  input  logic                  i_write,
  input  logic [WIDTH-1:0]      i_writedata
);

  localparam int unsigned ENTRIES = 1 << ELEMENTS_W;

  logic [WIDTH-1:0] r_mem [ENTRIES];
  logic [WIDTH-1:0] r_readdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_write) begin
      r_mem[i_writeaddress] <= i_writedata;
    end
  end

  // Read port; holds last data while read is low
  always_ff @(posedge clk) begin
    if (i_read) begin
      r_readdata <= r_mem[i_readaddress];
    end
  end

  assign o_readdata = r_readdata;

endmodule

// File: rtl/armleocpu_regfile_frontend.sv
// Register-file front end: zero-fill after reset, x0 hardwired to zero,
// writeback forwarding, and a one-entry valid/ready read response buffer.
module armleocpu_regfile_frontend
  import armleocpu_regfile_frontend_pkg::*;
#(
  parameter int unsigned ELEMENTS_W = ELEMENTS_W_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ELEMENTS_W-1:0] rs1_addr,
  input  logic [ELEMENTS_W-1:0] rs2_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rs1_data,
  output logic [WIDTH-1:0]      rs2_data,
  input  logic                  wb_write,
  input  logic [ELEMENTS_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data
);

  typedef enum logic {
    STATE_CLEAR = 1'b0,
    STATE_RUN   = 1'b1
  } state_t;

  localparam logic [ELEMENTS_W-1:0] ZERO_IDX = '0;
  localparam logic [ELEMENTS_W-1:0] LAST_IDX = '1;

  state_t                r_state, w_state_nxt;
  logic [ELEMENTS_W-1:0] r_counter, w_counter_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  w_accept;
  logic                  w_wr_en;
  logic [ELEMENTS_W-1:0] w_wr_addr;
  logic [WIDTH-1:0]      w_wr_data;
  logic [WIDTH-1:0]      w_lane1_rdata, w_lane2_rdata;

  logic                  r_rs1_zero, r_rs2_zero;
  logic                  r_rs1_fwd, r_rs2_fwd;
  logic [WIDTH-1:0]      r_rs1_fwd_data, r_rs2_fwd_data;

  // State, clear counter and response-valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= STATE_CLEAR;
      r_counter   <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_counter   <= w_counter_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  // Next state, handshake and shared write-port mux
  always_comb begin
    w_state_nxt     = r_state;
    w_counter_nxt   = r_counter;
    w_rsp_valid_nxt = r_rsp_valid;
    init_done       = 1'b0;
    req_ready       = 1'b0;
    w_accept        = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_addr       = r_counter;
    w_wr_data       = '0;
    case (r_state)
      STATE_CLEAR: begin
        w_wr_en       = 1'b1;
        w_counter_nxt = r_counter + ELEMENTS_W'(1);
        if (r_counter == LAST_IDX) begin
          w_state_nxt = STATE_RUN;
        end
      end
      STATE_RUN: begin
        init_done = 1'b1;
        req_ready = !r_rsp_valid || rsp_ready;
        w_accept  = req_valid && req_ready;
        w_wr_en   = wb_write && (wb_addr != ZERO_IDX);
        w_wr_addr = wb_addr;
        w_wr_data = wb_data;
        if (w_accept) begin
          w_rsp_valid_nxt = 1'b1;
        end else if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = STATE_CLEAR;
      end
    endcase
  end

  // Per-operand zero/forward flags captured at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_zero     <= 1'b1;
      r_rs2_zero     <= 1'b1;
      r_rs1_fwd      <= 1'b0;
      r_rs2_fwd      <= 1'b0;
      r_rs1_fwd_data <= '0;
      r_rs2_fwd_data <= '0;
    end else if (w_accept) begin
      r_rs1_zero     <= (rs1_addr == ZERO_IDX);
      r_rs2_zero     <= (rs2_addr == ZERO_IDX);
      r_rs1_fwd      <= wb_write && (wb_addr == rs1_addr) && (rs1_addr != ZERO_IDX);
      r_rs2_fwd      <= wb_write && (wb_addr == rs2_addr) && (rs2_addr != ZERO_IDX);
      r_rs1_fwd_data <= wb_data;
      r_rs2_fwd_data <= wb_data;
    end
  end

  armleocpu_regfile_one_lane #(
    .ELEMENTS_W (ELEMENTS_W),
    .WIDTH      (WIDTH)
  ) u_lane1 (
    .clk            (clk),
    .i_readaddress  (rs1_addr),
    .i_read         (w_accept),
    .o_readdata     (w_lane1_rdata),
    .i_writeaddress (w_wr_addr),
    .i_write        (w_wr_en),
    .i_writedata    (w_wr_data)
  );

  armleocpu_regfile_one_lane #(
    .ELEMENTS_W (ELEMENTS_W),
    .WIDTH      (WIDTH)
  ) u_lane2 (
    .clk            (clk),
    .i_readaddress  (rs2_addr),
    .i_read         (w_accept),
    .o_readdata     (w_lane2_rdata),
    .i_writeaddress (w_wr_addr),
    .i_write        (w_wr_en),
    .i_writedata    (w_wr_data)
  );

  assign rsp_valid = r_rsp_valid;
  assign rs1_data  = r_rs1_zero ? '0 : (r_rs1_fwd ? r_rs1_fwd_data : w_lane1_rdata);
  assign rs2_data  = r_rs2_zero ? '0 : (r_rs2_fwd ? r_rs2_fwd_data : w_lane2_rdata);

endmodule
